// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the 7-input truth-table sweep controller.
// Holds the state encoding and the self-dual classifier used at sweep completion.
package tt_sweep_pkg;

    localparam int N_IN   = 7;
    localparam int N_VEC  = 128;
    localparam int ONES_W = 8;
    localparam int HALF   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // f is self-dual when every complementary vector pair k / 127-k disagrees.
    function automatic logic is_selfdual(input logic [N_VEC-1:0] t);
        logic r;
        r = 1'b1;
        for (int k = 0; k < HALF; k++) begin
            r = r & (t[k] ^ t[N_VEC-1-k]);
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_tag_pipe.sv
// Delay line carrying {valid, vector index} alongside the external function latency.
// Zero depth degenerates to a wire; a flush kills everything in flight.
module tt_tag_pipe
    import tt_sweep_pkg::*;
#(
    parameter int FN_LAT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_tag,
    output logic            out_valid,
    output logic [N_IN-1:0] out_tag
);

    generate
        if (FN_LAT == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid      = in_valid & ~flush;
            assign out_tag        = in_tag;
        end else begin : g_shift
            logic [N_IN:0] stage_q [FN_LAT];
            logic [N_IN:0] stage_d [FN_LAT];

            // next value of each stage: shift by one, or clear on flush
            always_comb begin
                if (flush) begin
                    stage_d[0] = {(N_IN+1){1'b0}};
                end else begin
                    stage_d[0] = {in_valid, in_tag};
                end
                for (int i = 1; i < FN_LAT; i++) begin
                    if (flush) begin
                        stage_d[i] = {(N_IN+1){1'b0}};
                    end else begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            // stage registers
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < FN_LAT; i++) begin
                        stage_q[i] <= {(N_IN+1){1'b0}};
                    end
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign {out_valid, out_tag} = stage_q[FN_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Drives an external 7-input function through all 128 vectors, captures its truth
// table and classifies it (weight, constant, balanced, self-dual) on completion.
module tt_sweep_ctrl
    import tt_sweep_pkg::*;
#(
    parameter int FN_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   x,
    input  logic              f_in,
    output logic              busy,
    output logic              done,
    output logic              tt_valid,
    output logic [N_VEC-1:0]  tt,
    output logic [ONES_W-1:0] ones,
    output logic              const0,
    output logic              const1,
    output logic              balanced,
    output logic              selfdual
);

    state_e              state_q, state_d;
    logic [N_IN-1:0]     x_q, x_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tt_valid_q, tt_valid_d;
    logic [N_VEC-1:0]    tt_q, tt_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                const0_q, const0_d;
    logic                const1_q, const1_d;
    logic                balanced_q, balanced_d;
    logic                selfdual_q, selfdual_d;

    logic                in_sweep_s;
    logic                flush_s;
    logic                cap_valid_s;
    logic [N_IN-1:0]     cap_tag_s;

    assign in_sweep_s = (state_q == SWEEP);
    assign flush_s    = abort & ((state_q == SWEEP) | (state_q == DRAIN));

    tt_tag_pipe #(
        .FN_LAT (FN_LAT)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_s),
        .in_valid  (in_sweep_s),
        .in_tag    (x_q),
        .out_valid (cap_valid_s),
        .out_tag   (cap_tag_s)
    );

    // next-state, capture and classification logic
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        tt_valid_d = tt_valid_q;
        tt_d       = tt_q;
        ones_d     = ones_q;
        const0_d   = const0_q;
        const1_d   = const1_q;
        balanced_d = balanced_q;
        selfdual_d = selfdual_q;

        if (cap_valid_s && !flush_s) begin
            tt_d[cap_tag_s] = f_in;
            ones_d          = ones_q + {{(ONES_W-1){1'b0}}, f_in};
        end else begin
            tt_d = tt_q;
        end

        case (state_q)
            IDLE: begin
                x_d = {N_IN{1'b0}};
                if (start) begin
                    state_d    = SWEEP;
                    tt_d       = {N_VEC{1'b0}};
                    ones_d     = {ONES_W{1'b0}};
                    tt_valid_d = 1'b0;
                    const0_d   = 1'b0;
                    const1_d   = 1'b0;
                    balanced_d = 1'b0;
                    selfdual_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (flush_s) begin
                    state_d = IDLE;
                    x_d     = {N_IN{1'b0}};
                end else if (x_q == N_IN'(N_VEC-1)) begin
                    state_d = (FN_LAT == 0) ? DONE : DRAIN;
                end else begin
                    x_d = x_q + 7'd1;
                end
            end
            DRAIN: begin
                if (flush_s) begin
                    state_d = IDLE;
                    x_d     = {N_IN{1'b0}};
                end else if (cap_valid_s && (cap_tag_s == N_IN'(N_VEC-1))) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
                x_d     = {N_IN{1'b0}};
            end
            default: begin
                state_d = IDLE;
                x_d     = {N_IN{1'b0}};
            end
        endcase

        // flags see the table including the final capture made on the same edge
        if ((state_d == DONE) && (state_q != DONE)) begin
            tt_valid_d = 1'b1;
            const0_d   = (tt_d == {N_VEC{1'b0}});
            const1_d   = &tt_d;
            balanced_d = (ones_d == ONES_W'(HALF));
            selfdual_d = is_selfdual(tt_d);
        end else begin
            tt_valid_d = tt_valid_d;
        end

        busy_d = (state_d == SWEEP) | (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= {N_IN{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_valid_q <= 1'b0;
            tt_q       <= {N_VEC{1'b0}};
            ones_q     <= {ONES_W{1'b0}};
            const0_q   <= 1'b0;
            const1_q   <= 1'b0;
            balanced_q <= 1'b0;
            selfdual_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tt_valid_q <= tt_valid_d;
            tt_q       <= tt_d;
            ones_q     <= ones_d;
            const0_q   <= const0_d;
            const1_q   <= const1_d;
            balanced_q <= balanced_d;
            selfdual_q <= selfdual_d;
        end
    end

    assign x        = x_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt_valid = tt_valid_q;
    assign tt       = tt_q;
    assign ones     = ones_q;
    assign const0   = const0_q;
    assign const1   = const1_q;
    assign balanced = balanced_q;
    assign selfdual = selfdual_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Scoreboard bench for tt_sweep_ctrl: one instance with zero function latency,
// one with three cycles, each fed by a bench-side model of the function block.
module tb_tt_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         d0_start = 1'b0, d0_abort = 1'b0, d0_f;
    logic [6:0]   d0_x;
    logic         d0_busy, d0_done, d0_ttv, d0_c0, d0_c1, d0_bal, d0_sd;
    logic [127:0] d0_tt;
    logic [7:0]   d0_ones;

    logic         d3_start = 1'b0, d3_abort = 1'b0, d3_f;
    logic [6:0]   d3_x;
    logic         d3_busy, d3_done, d3_ttv, d3_c0, d3_c1, d3_bal, d3_sd;
    logic [127:0] d3_tt;
    logic [7:0]   d3_ones;
    logic         p1, p2, p3;

    int mode0 = 0;
    int mode3 = 4;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        logic [127:0] tt;
        logic [7:0]   ones;
        logic         c0, c1, bal, sd;
        int           lat;
    } exp_t;
    exp_t sb[$];

    tt_sweep_ctrl #(.FN_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(d0_start), .abort(d0_abort), .x(d0_x), .f_in(d0_f),
        .busy(d0_busy), .done(d0_done), .tt_valid(d0_ttv), .tt(d0_tt), .ones(d0_ones),
        .const0(d0_c0), .const1(d0_c1), .balanced(d0_bal), .selfdual(d0_sd)
    );

    tt_sweep_ctrl #(.FN_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(d3_start), .abort(d3_abort), .x(d3_x), .f_in(d3_f),
        .busy(d3_busy), .done(d3_done), .tt_valid(d3_ttv), .tt(d3_tt), .ones(d3_ones),
        .const0(d3_c0), .const1(d3_c1), .balanced(d3_bal), .selfdual(d3_sd)
    );

    function automatic logic fn(input int m, input logic [6:0] v);
        case (m)
            0: return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
            1: return 1'b0;
            2: return 1'b1;
            3: return &v;
            4: return v[6];
            5: return ^v;
            default: return 1'b0;
        endcase
    endfunction

    assign d0_f = fn(mode0, d0_x);

    // three-register latency model for the second instance
    always @(posedge clk) begin
        p1 <= fn(mode3, d3_x);
        p2 <= p1;
        p3 <= p2;
    end
    assign d3_f = p3;

    function automatic logic [127:0] obs(input int sel, input int f);
        case (f)
            0: return sel ? d3_tt : d0_tt;
            1: return 128'(sel ? d3_ones : d0_ones);
            2: return 128'(sel ? d3_c0 : d0_c0);
            3: return 128'(sel ? d3_c1 : d0_c1);
            4: return 128'(sel ? d3_bal : d0_bal);
            5: return 128'(sel ? d3_sd : d0_sd);
            6: return 128'(sel ? d3_ttv : d0_ttv);
            7: return 128'(sel ? d3_busy : d0_busy);
            8: return 128'(sel ? d3_done : d0_done);
            9: return 128'(sel ? d3_x : d0_x);
            default: return 128'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic ab);
        if (sel != 0) begin
            d3_start = st; d3_abort = ab;
        end else begin
            d0_start = st; d0_abort = ab;
        end
    endtask

    function automatic exp_t model(input int m, input int lat);
        exp_t e;
        int cnt;
        logic sd;
        cnt = 0;
        sd = 1'b1;
        for (int k = 0; k < 128; k++) begin
            e.tt[k] = fn(m, 7'(k));
            cnt += int'(e.tt[k]);
        end
        for (int k = 0; k < 128; k++) begin
            if (e.tt[k] == e.tt[127-k]) sd = 1'b0;
        end
        e.ones = 8'(cnt);
        e.c0   = (cnt == 0);
        e.c1   = (cnt == 128);
        e.bal  = (cnt == 64);
        e.sd   = sd;
        e.lat  = lat;
        return e;
    endfunction

    task automatic run(input int sel, input int m, input bit abort_idle, input bit mid_start);
        exp_t e;
        int n;
        int bad_busy;
        if (sel != 0) mode3 = m; else mode0 = m;
        sb.push_back(model(m, sel ? 3 : 0));
        @(negedge clk);
        drive(sel, 1'b1, abort_idle);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0);
        n = 1;
        bad_busy = 0;
        while (obs(sel, 8) == 128'd0 && n < 300) begin
            if (obs(sel, 7) != 128'd1) bad_busy++;
            drive(sel, mid_start && (n == 60), 1'b0);
            @(negedge clk);
            n++;
        end
        drive(sel, 1'b0, 1'b0);
        e = sb.pop_front();
        check("latency", 128'(n), 128'(129 + e.lat));
        check("busy_during_sweep", 128'(bad_busy), 128'd0);
        check("tt", obs(sel, 0), e.tt);
        check("ones", obs(sel, 1), 128'(e.ones));
        check("const0", obs(sel, 2), 128'(e.c0));
        check("const1", obs(sel, 3), 128'(e.c1));
        check("balanced", obs(sel, 4), 128'(e.bal));
        check("selfdual", obs(sel, 5), 128'(e.sd));
        check("tt_valid", obs(sel, 6), 128'd1);
        check("busy_at_done", obs(sel, 7), 128'd0);
        @(negedge clk);
        check("done_pulse", obs(sel, 8), 128'd0);
        check("tt_hold", obs(sel, 0), e.tt);
        check("tt_valid_hold", obs(sel, 6), 128'd1);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 10; f++) begin
            check("reset_d0", obs(0, f), 128'd0);
            check("reset_d3", obs(1, f), 128'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run(0, 0, 1'b0, 1'b0);
        check("maj_ones", 128'(d0_ones), 128'd64);
        run(0, 1, 1'b0, 1'b0);
        run(0, 2, 1'b0, 1'b0);
        check("one_ones", 128'(d0_ones), 128'd128);
        run(0, 3, 1'b0, 1'b0);
        check("and_tt", d0_tt, {1'b1, 127'd0});
        run(0, 5, 1'b1, 1'b0);
        run(0, 0, 1'b0, 1'b1);
        run(1, 4, 1'b0, 1'b0);
        check("x6_tt", d3_tt, {64'hFFFF_FFFF_FFFF_FFFF, 64'd0});

        // abort fifty cycles into the sweep
        mode0 = 3;
        drive(0, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        drive(0, 1'b0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0);
        check("abort_x", obs(0, 9), 128'd0);
        check("abort_busy", obs(0, 7), 128'd0);
        check("abort_tt_valid", obs(0, 6), 128'd0);
        seen = 0;
        repeat (140) begin
            @(negedge clk);
            if (d0_done) seen++;
        end
        check("abort_no_done", 128'(seen), 128'd0);
        check("abort_tt_valid_after", obs(0, 6), 128'd0);
        run(0, 3, 1'b0, 1'b0);

        // asynchronous reset while draining
        mode3 = 4;
        drive(1, 1'b1, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0);
        repeat (129) @(negedge clk);
        check("drain_busy", obs(1, 7), 128'd1);
        #2 rst = 1'b1;
        #1;
        for (int f = 0; f < 10; f++) begin
            check("async_rst", obs(1, f), 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(1, 4, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
